decode_64b_66b: RTL and testbench

- Receive-side 64b/66b decoder between the GTX RX gearbox (66-bit blocks as 64-bit payload + 2-bit sync header) and the XGMII RX interface of the MAC.
- Acquires block lock from sync headers and drives bitslip requests to the gearbox.
- Decodes data and control blocks into 64-bit XGMII rxd/rxc.
- Substitutes error or local-fault columns for illegal blocks and loss of lock.

---
 rtl/decode_64b_66b.sv | 270 +++++++++++++++++++++++++++
 tb/tb_decode_64b_66b.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_64b_66b.sv
// Receive-side 64b/66b decoder: sync-header block lock with gearbox bitslip, and block to XGMII rxd/rxc.
// Optional DECODE_SEQ_CHECK_EN adds start/data/terminate frame sequencing checks.

module decode_66b_term_lane #(
  parameter int LANE  = 0,
  parameter int VEC_W = 8
) (
  input  logic [2:0]       k_i,
  input  logic [VEC_W-1:0] byte_i,
  output logic [VEC_W-1:0] rxd_o,
  output logic             rxc_o,
  output logic             rsvd_bad_o
);
  // byte_i is payload byte LANE+1: data for lanes below k, a must-be-zero byte otherwise
  always_comb begin
    rxd_o      = byte_i;
    rxc_o      = 1'b0;
    rsvd_bad_o = 1'b0;
    if (3'(LANE) >= k_i) begin
      rxd_o      = (3'(LANE) == k_i) ? VEC_W'(8'hFD) : VEC_W'(8'h07);
      rxc_o      = 1'b1;
      rsvd_bad_o = |byte_i;
    end
  end
endmodule

module decode_64b_66b #(
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] decode_data_i,
  input  logic [1:0]  decode_head_i,
  input  logic        decode_data_vld_i,
  output logic [63:0] xgmii_rxd_o,
  output logic [7:0]  xgmii_rxc_o,
  output logic        xgmii_rxd_vld_o,
  output logic        decode_error_o,
  output logic        block_lock_o,
  output logic        slip_o
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 8;
  localparam int CW        = $clog2(SH_CNT_MAX + 1);
  localparam int IW        = $clog2(SH_INVLD_MAX + 1);
  localparam int SW        = $clog2(SLIP_WAIT + 1);

  localparam logic [63:0] IDLE_COL = 64'h0707070707070707;
  localparam logic [63:0] LF_COL   = 64'h0100009C0100009C;
  localparam logic [63:0] ERR_COL  = 64'hFEFEFEFEFEFEFEFE;

  typedef enum logic [2:0] {LOCK_INIT, TEST_SH, LOCKED, SLIP, SLIP_SETTLE} lock_state_e;

  typedef struct packed {
    logic [63:0] rxd;
    logic [7:0]  rxc;
    logic        bad;
  } dec_t;

  lock_state_e state, state_n;
  logic [CW-1:0] sh_cnt, sh_cnt_n, sh_base, sh_inc;
  logic [IW-1:0] invld_cnt, invld_cnt_n, invld_inc;
  logic [SW-1:0] slip_cnt, slip_cnt_n;
  logic          lock_n, hdr_ok;

  assign hdr_ok    = decode_head_i[1] ^ decode_head_i[0];
  assign sh_base   = (state == LOCK_INIT) ? '0 : sh_cnt;
  assign sh_inc    = sh_base + CW'(1);
  assign invld_inc = invld_cnt + IW'(!hdr_ok);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= LOCK_INIT;
      sh_cnt       <= '0;
      invld_cnt    <= '0;
      slip_cnt     <= '0;
      block_lock_o <= 1'b0;
      slip_o       <= 1'b0;
    end else begin
      state        <= state_n;
      sh_cnt       <= sh_cnt_n;
      invld_cnt    <= invld_cnt_n;
      slip_cnt     <= slip_cnt_n;
      block_lock_o <= lock_n;
      slip_o       <= (state_n == SLIP);
    end
  end

  always_comb begin
    state_n     = state;
    sh_cnt_n    = sh_cnt;
    invld_cnt_n = invld_cnt;
    slip_cnt_n  = slip_cnt;
    lock_n      = block_lock_o;
    case (state)
      LOCK_INIT, TEST_SH: if (decode_data_vld_i) begin
        invld_cnt_n = '0;
        if (!hdr_ok) begin
          state_n  = SLIP;
          sh_cnt_n = '0;
        end else if (sh_inc == CW'(SH_CNT_MAX)) begin
          state_n  = LOCKED;
          lock_n   = 1'b1;
          sh_cnt_n = '0;
        end else begin
          state_n  = TEST_SH;
          sh_cnt_n = sh_inc;
        end
      end
      LOCKED: if (decode_data_vld_i) begin
        // lock loss is tested first so it wins over a coincident window end
        if (invld_inc == IW'(SH_INVLD_MAX)) begin
          state_n     = SLIP;
          lock_n      = 1'b0;
          sh_cnt_n    = '0;
          invld_cnt_n = '0;
        end else if (sh_inc == CW'(SH_CNT_MAX)) begin
          sh_cnt_n    = '0;
          invld_cnt_n = '0;
        end else begin
          sh_cnt_n    = sh_inc;
          invld_cnt_n = invld_inc;
        end
      end
      // a block arriving during the slip pulse already counts toward settling
      SLIP: begin
        state_n    = SLIP_SETTLE;
        slip_cnt_n = SW'(decode_data_vld_i);
      end
      SLIP_SETTLE: if (decode_data_vld_i) begin
        if (slip_cnt + SW'(1) == SW'(SLIP_WAIT)) begin
          state_n     = LOCK_INIT;
          slip_cnt_n  = '0;
          sh_cnt_n    = '0;
          invld_cnt_n = '0;
        end else begin
          slip_cnt_n = slip_cnt + SW'(1);
        end
      end
      default: state_n = LOCK_INIT;
    endcase
  end

  logic [7:0]  blk_type;
  logic        is_term;
  logic [2:0]  term_k;
  logic [71:0] pay_ext;
  logic [NUM_LANES-1:0][VEC_W-1:0] term_rxd;
  logic [NUM_LANES-1:0]            term_rxc, term_rsvd;

  assign blk_type = decode_data_i[7:0];
  assign pay_ext  = {8'h00, decode_data_i};

  always_comb begin
    is_term = 1'b1;
    term_k  = 3'd0;
    case (blk_type)
      8'h87: term_k = 3'd0;
      8'h99: term_k = 3'd1;
      8'hAA: term_k = 3'd2;
      8'hB4: term_k = 3'd3;
      8'hCC: term_k = 3'd4;
      8'hD2: term_k = 3'd5;
      8'hE1: term_k = 3'd6;
      8'hFF: term_k = 3'd7;
      default: is_term = 1'b0;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    decode_66b_term_lane #(.LANE(g), .VEC_W(VEC_W)) u_lane (
      .k_i        (term_k),
      .byte_i     (pay_ext[VEC_W*(g+1) +: VEC_W]),
      .rxd_o      (term_rxd[g]),
      .rxc_o      (term_rxc[g]),
      .rsvd_bad_o (term_rsvd[g])
    );
  end

  dec_t dec, dec_out;
  logic seq_bad;

  always_comb begin
    dec.rxd = ERR_COL;
    dec.rxc = 8'hff;
    dec.bad = 1'b1;
    if (decode_head_i == 2'b10) begin
      dec.rxd = decode_data_i;
      dec.rxc = 8'h00;
      dec.bad = 1'b0;
    end else if (decode_head_i == 2'b01) begin
      case (blk_type)
        8'h1E: if (decode_data_i[63:8] == '0) begin
          dec.rxd = IDLE_COL;
          dec.bad = 1'b0;
        end
        8'h78: begin
          dec.rxd = {decode_data_i[63:8], 8'hFB};
          dec.rxc = 8'h01;
          dec.bad = 1'b0;
        end
        8'h33: begin
          dec.rxd = {decode_data_i[63:40], 8'hFB, 32'h07070707};
          dec.rxc = 8'h1f;
          dec.bad = 1'b0;
        end
        default: if (is_term && !(|term_rsvd)) begin
          dec.rxd = term_rxd;
          dec.rxc = term_rxc;
          dec.bad = 1'b0;
        end
      endcase
    end
  end

`ifdef DECODE_SEQ_CHECK_EN
  logic in_frame, blk_start, blk_term, blk_data;

  assign blk_data  = (decode_head_i == 2'b10);
  assign blk_start = (decode_head_i == 2'b01) && (blk_type == 8'h78 || blk_type == 8'h33);
  assign blk_term  = (decode_head_i == 2'b01) && is_term;
  assign seq_bad   = !dec.bad && ((blk_start && in_frame) || ((blk_data || blk_term) && !in_frame));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                      in_frame <= 1'b0;
    else if (!block_lock_o || !lock_n) in_frame <= 1'b0;
    else if (decode_data_vld_i) begin
      if (dec_out.bad)    in_frame <= 1'b0;
      else if (blk_start) in_frame <= 1'b1;
      else if (blk_term)  in_frame <= 1'b0;
    end
  end
`else
  assign seq_bad = 1'b0;
`endif

  always_comb begin
    dec_out = dec;
    if (seq_bad) begin
      dec_out.rxd = ERR_COL;
      dec_out.rxc = 8'hff;
      dec_out.bad = 1'b1;
    end
  end

  // lock is sampled before this block's own lock update, so the locking block still shows fault
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      xgmii_rxd_o     <= IDLE_COL;
      xgmii_rxc_o     <= 8'hff;
      xgmii_rxd_vld_o <= 1'b0;
      decode_error_o  <= 1'b0;
    end else begin
      xgmii_rxd_vld_o <= decode_data_vld_i;
      decode_error_o  <= 1'b0;
      if (decode_data_vld_i) begin
        if (block_lock_o) begin
          xgmii_rxd_o    <= dec_out.rxd;
          xgmii_rxc_o    <= dec_out.rxc;
          decode_error_o <= dec_out.bad;
        end else begin
          xgmii_rxd_o <= LF_COL;
          xgmii_rxc_o <= 8'h11;
        end
      end
    end
  end
endmodule

// File: tb/tb_decode_64b_66b.sv
// Randomized scoreboard bench for decode_64b_66b against a block-level reference model.
module tb_decode_64b_66b;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [63:0] decode_data_i = '0;
  logic [1:0]  decode_head_i = '0;
  logic        decode_data_vld_i = 1'b0;
  logic [63:0] xgmii_rxd_o;
  logic [7:0]  xgmii_rxc_o;
  logic        xgmii_rxd_vld_o, decode_error_o, block_lock_o, slip_o;

  decode_64b_66b dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .decode_data_i     (decode_data_i),
    .decode_head_i     (decode_head_i),
    .decode_data_vld_i (decode_data_vld_i),
    .xgmii_rxd_o       (xgmii_rxd_o),
    .xgmii_rxc_o       (xgmii_rxc_o),
    .xgmii_rxd_vld_o   (xgmii_rxd_vld_o),
    .decode_error_o    (decode_error_o),
    .block_lock_o      (block_lock_o),
    .slip_o            (slip_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [63:0] IDLE = 64'h0707070707070707;
  localparam logic [63:0] LF   = 64'h0100009C0100009C;
  localparam logic [63:0] ERRC = 64'hFEFEFEFEFEFEFEFE;

  typedef struct packed {
    logic [63:0] rxd;
    logic [7:0]  rxc;
    logic        err;
    logic        lock;
    logic        slip;
  } exp_t;

  localparam exp_t RST_EXP = '{rxd: IDLE, rxc: 8'hff, err: 1'b0, lock: 1'b0, slip: 1'b0};

  exp_t q[$];
  int n_chk = 0, n_fail = 0;

  // reference model state: mode 0 hunting, 1 locked, 2 settling after a slip
  int m_mode, m_cnt, m_inv, m_settle;
  bit m_lock, m_in_frame;

  task automatic check_blk(input string nm, input exp_t a, input exp_t e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got rxd=%h rxc=%h err=%b lock=%b slip=%b, expected rxd=%h rxc=%h err=%b lock=%b slip=%b",
               nm, a.rxd, a.rxc, a.err, a.lock, a.slip, e.rxd, e.rxc, e.err, e.lock, e.slip);
    end
  endtask

  task automatic check_reset(input string nm);
    logic [75:0] a, e;
    a = {xgmii_rxd_o, xgmii_rxc_o, xgmii_rxd_vld_o, decode_error_o, block_lock_o, slip_o};
    e = {IDLE, 8'hff, 4'b0000};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_cnt = 0; m_inv = 0; m_settle = 0; m_lock = 0; m_in_frame = 0;
  endfunction

  // kind: 0 idle/other, 1 start, 2 data, 3 terminate
  function automatic void ref_decode(input logic [1:0] h, input logic [63:0] d,
                                     output logic [63:0] rxd, output logic [7:0] rxc,
                                     output bit bad, output int kind);
    logic [7:0] b[8];
    logic [7:0] ln[8];
    logic [7:0] tcodes[8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    int k = -1;
    bad = 0; kind = 0; rxc = 8'hff;
    for (int i = 0; i < 8; i++) begin b[i] = d[8*i +: 8]; ln[i] = 8'h07; end
    if (h == 2'b10) begin
      for (int i = 0; i < 8; i++) ln[i] = b[i];
      rxc = 8'h00; kind = 2;
    end else if (h == 2'b01) begin
      for (int i = 0; i < 8; i++) if (b[0] == tcodes[i]) k = i;
      if (b[0] == 8'h1E) begin
        for (int i = 1; i < 8; i++) if (b[i] != 0) bad = 1;
      end else if (b[0] == 8'h78) begin
        ln[0] = 8'hFB;
        for (int i = 1; i < 8; i++) ln[i] = b[i];
        rxc = 8'h01; kind = 1;
      end else if (b[0] == 8'h33) begin
        ln[4] = 8'hFB;
        for (int i = 5; i < 8; i++) ln[i] = b[i];
        rxc = 8'h1f; kind = 1;
      end else if (k >= 0) begin
        kind = 3; rxc = 8'h00;
        for (int j = 0; j < 8; j++) begin
          if (j < k) ln[j] = b[j+1];
          else begin
            rxc[j] = 1'b1;
            ln[j] = (j == k) ? 8'hFD : 8'h07;
          end
          if (j > k && b[j] != 0) bad = 1;
        end
      end else bad = 1;
    end else bad = 1;
    for (int i = 0; i < 8; i++) rxd[8*i +: 8] = ln[i];
    if (bad) begin rxd = ERRC; rxc = 8'hff; end
  endfunction

  function automatic void model_block(input logic [1:0] h, input logic [63:0] d);
    exp_t e;
    logic [63:0] rxd;
    logic [7:0] rxc;
    bit bad, hv;
    int kind;
    hv = (h == 2'b01) || (h == 2'b10);
    e = '0;
    if (m_lock) begin
      ref_decode(h, d, rxd, rxc, bad, kind);
`ifdef DECODE_SEQ_CHECK_EN
      if (!bad && ((kind == 1 && m_in_frame) || ((kind == 2 || kind == 3) && !m_in_frame))) begin
        bad = 1; rxd = ERRC; rxc = 8'hff;
      end
      if (bad) m_in_frame = 0;
      else if (kind == 1) m_in_frame = 1;
      else if (kind == 3) m_in_frame = 0;
`endif
      e.rxd = rxd; e.rxc = rxc; e.err = bad;
    end else begin
      e.rxd = LF; e.rxc = 8'h11;
    end
    case (m_mode)
      0: if (!hv) begin
           m_mode = 2; m_settle = 32; e.slip = 1;
         end else begin
           m_cnt++;
           if (m_cnt == 64) begin m_lock = 1; m_mode = 1; m_cnt = 0; m_inv = 0; end
         end
      1: begin
           m_cnt++;
           if (!hv) m_inv++;
           if (m_inv == 16) begin
             m_lock = 0; m_mode = 2; m_settle = 32; e.slip = 1; m_cnt = 0; m_inv = 0;
           end else if (m_cnt == 64) begin
             m_cnt = 0; m_inv = 0;
           end
         end
      default: begin
           m_settle--;
           if (m_settle == 0) begin m_mode = 0; m_cnt = 0; end
         end
    endcase
    if (!m_lock) m_in_frame = 0;
    e.lock = m_lock;
    q.push_back(e);
  endfunction

  task automatic send(input bit v, input logic [1:0] h, input logic [63:0] d);
    @(posedge clk_i);
    #1;
    decode_data_vld_i = v;
    decode_head_i     = h;
    decode_data_i     = d;
    if (v) model_block(h, d);
  endtask

  task automatic send_idles(input int n);
    for (int i = 0; i < n; ) begin
      if ($urandom_range(0, 4) == 0) send(1'b0, 2'($urandom), {$urandom, $urandom});
      else begin send(1'b1, 2'b01, 64'h1E); i++; end
    end
  endtask

  task automatic rand_blocks(input int n, input int bad_pct);
    logic [7:0] types[12] = '{8'h1E, 8'h78, 8'h33, 8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC,
                              8'hD2, 8'hE1, 8'hFF, 8'h55};
    for (int i = 0; i < n; i++) begin
      bit v;
      int r, idx;
      logic [1:0] h;
      logic [63:0] d;
      v = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 99);
      if (r < bad_pct) h = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
      else if (r < bad_pct + 35) h = 2'b10;
      else h = 2'b01;
      d = {$urandom, $urandom};
      if (h == 2'b01) begin
        idx = $urandom_range(0, 12);
        d[7:0] = (idx == 12) ? 8'($urandom) : types[idx];
        if ($urandom_range(0, 3) != 0) begin
          if (idx == 0) d[63:8] = '0;
          else if (idx >= 3 && idx <= 10)
            for (int j = idx - 2; j < 8; j++) d[8*j +: 8] = 8'h00;
        end
      end
      send(v, h, d);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1 decode_data_vld_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1 check_reset("reset_mid");
    model_reset();
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b1;
  endtask

  // monitor: pops one expectation per output beat, otherwise expects held outputs
  exp_t last = RST_EXP;
  always @(negedge clk_i) begin : mon
    exp_t a, e;
    a = {xgmii_rxd_o, xgmii_rxc_o, decode_error_o, block_lock_o, slip_o};
    if (!rst_i) last = RST_EXP;
    else if (xgmii_rxd_vld_o) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_output: got rxd=%h with no expected block, expected none", xgmii_rxd_o);
      end else begin
        e = q.pop_front();
        check_blk("block", a, e);
        last = e;
      end
    end else begin
      e = last; e.err = 1'b0; e.slip = 1'b0;
      check_blk("hold", a, e);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk_i);
    #1 check_reset("reset_init");
    #3 rst_i = 1'b1;

    // acquire lock, then directed decode cases
    send_idles(68);
    send(1'b1, 2'b01, {56'hAABBCCDDEEFF11, 8'h78});
    send(1'b1, 2'b10, 64'h0123456789ABCDEF);
    send(1'b1, 2'b01, {32'h0, 24'h332211, 8'hB4});
    send(1'b1, 2'b01, 64'h55);
    send(1'b1, 2'b01, 64'h1E);
    send(1'b1, 2'b01, {56'h1, 8'h78});
    send(1'b1, 2'b01, {56'h2, 8'h78});
    send(1'b1, 2'b01, 64'h1E);
    send(1'b1, 2'b01, {56'h0, 8'h87});
    send(1'b1, 2'b01, {56'h0, 8'h33});
    send(1'b1, 2'b01, {8'h0, 48'h665544332211, 8'hE1});
    send(1'b1, 2'b01, {56'h1, 8'h1E});

    // window-aligned invalid-header runs: 15 holds lock, 16 drops it
    do_reset();
    send_idles(64);
    for (int i = 0; i < 64; i++) send(1'b1, (i < 15) ? 2'b11 : 2'b01, 64'h1E);
    for (int i = 0; i < 16; i++) send(1'b1, (i[0]) ? 2'b00 : 2'b11, 64'h1E);
    send_idles(32);
    send_idles(10);
    send(1'b1, 2'b11, 64'h1E);
    send_idles(32 + 64 + 3);

    rand_blocks(1200, 3);
    rand_blocks(300, 25);
    send_idles(100);
    rand_blocks(400, 2);

    do_reset();
    send_idles(70);
    send(1'b1, 2'b01, {56'h3, 8'h78});
    send(1'b1, 2'b01, {56'h4, 8'h78});
    send(1'b1, 2'b01, 64'h1E);

    repeat (4) send(1'b0, 2'b00, 64'h0);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending blocks, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
